// File: rtl/calc_pkg.sv
// calc_pkg: opcodes, error codes, sequencer states and opcode classification
package calc_pkg;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MULT = 4'd2, OP_DIV = 4'd3, OP_MOD = 4'd4,
                         OP_AND = 4'd5, OP_PRESET = 4'd13, OP_NOOP = 4'd14, OP_GRND = 4'd15;
  localparam logic [1:0] ERR_NONE = 2'b00, ERR_DIVZ = 2'b01, ERR_OVF = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  function automatic logic is_multicycle(input logic [3:0] op);
    return op == OP_DIV || op == OP_MOD;
  endfunction
  function automatic logic is_special(input logic [3:0] op);
    return op >= OP_PRESET;
  endfunction
endpackage

// File: rtl/calc_if.sv
// calc_if: command and response valid/ready channels of the calculator sequencer
interface calc_if #(parameter int WIDTH = 32);
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [3:0] cmd_opcode;
  logic [WIDTH-1:0] cmd_operand, rsp_result;
  logic [1:0] rsp_error;
  modport master(output cmd_valid, cmd_opcode, cmd_operand, rsp_ready,
                 input cmd_ready, rsp_valid, rsp_result, rsp_error);
  modport slave(input cmd_valid, cmd_opcode, cmd_operand, rsp_ready,
                output cmd_ready, rsp_valid, rsp_result, rsp_error);
endinterface

// File: rtl/calc_op_timer.sv
// calc_op_timer: loadable 4-bit down-counter, done while the count is 1
module calc_op_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? load_val : cnt - {3'b0, cnt != 4'd0};
  assign done = cnt == 4'd1;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: one-command-at-a-time controller owning the accumulator and sticky error
module calc_sequencer import calc_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DIV_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  calc_if.slave            bus,
  output logic [3:0]       op_code,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] mux_result,
  input  logic [1:0]       error_code,
  output logic [WIDTH-1:0] acc,
  output logic [1:0]       err_sticky
);
  state_t state, state_nx;
  logic [3:0] opc;
  logic [WIDTH-1:0] opnd;
  logic [1:0] rsp_err;
  logic accept, special, done, sample;
  assign accept = state == S_IDLE && bus.cmd_valid;
  assign special = is_special(bus.cmd_opcode);
  assign sample = state == S_EXEC && done;
  calc_op_timer u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept && !special),
    .load_val(is_multicycle(bus.cmd_opcode) ? 4'(DIV_LATENCY) : 4'd1),
    .done(done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = accept ? (special ? S_RESP : S_EXEC)
             : sample ? S_RESP
             : (state == S_RESP && bus.rsp_ready) ? S_IDLE : state;
  end
  // special opcodes take effect on the accept edge; datapath ops on the sample edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opc <= OP_NOOP;
      opnd <= '0;
      acc <= '0;
      err_sticky <= ERR_NONE;
      rsp_err <= ERR_NONE;
    end else if (accept) begin
      opc <= bus.cmd_opcode;
      opnd <= bus.cmd_operand;
      rsp_err <= ERR_NONE;
      if (bus.cmd_opcode == OP_PRESET) acc <= bus.cmd_operand;
      if (bus.cmd_opcode == OP_GRND) begin
        acc <= '0;
        err_sticky <= ERR_NONE;
      end
    end else if (sample) begin
      rsp_err <= error_code;
      err_sticky <= err_sticky | error_code;
      if (error_code == ERR_NONE) acc <= mux_result;
    end
  assign bus.cmd_ready = state == S_IDLE;
  assign bus.rsp_valid = state == S_RESP;
  assign bus.rsp_result = acc;
  assign bus.rsp_error = rsp_err;
  assign op_code = state == S_EXEC ? opc : OP_NOOP;
  assign op_a = acc;
  assign op_b = opnd;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench with a behavioural datapath around calc_sequencer
module tb_calc_sequencer;
  import calc_pkg::*;
  localparam int W = 32, LAT = 4;
  typedef struct packed {logic [W-1:0] res; logic [1:0] err;} exp_t;
  logic clk = 0, rst_n = 0;
  logic [3:0] op_code;
  logic [W-1:0] op_a, op_b, mux_result, acc;
  logic [1:0] error_code, err_sticky, err_inj = 2'b00;
  logic [W-1:0] m_acc = '0;
  logic [1:0] m_sticky = 2'b00;
  exp_t sb[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  calc_if #(.WIDTH(W)) bus();
  calc_sequencer #(.WIDTH(W), .DIV_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .mux_result(mux_result), .error_code(error_code), .acc(acc), .err_sticky(err_sticky)
  );
  function automatic logic [W-1:0] alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MULT: return a * b;
      OP_DIV:  return b == 0 ? '1 : a / b;
      OP_MOD:  return b == 0 ? a : a % b;
      OP_AND:  return a & b;
      default: return a ^ b;
    endcase
  endfunction
  assign mux_result = alu(op_code, op_a, op_b);
  assign error_code = op_code == OP_NOOP ? 2'b00 : err_inj;
  // one command end-to-end: accept, latency, optional ready hold, scoreboard, final state
  task automatic cmd(input logic [3:0] op, input logic [W-1:0] b, input logic [1:0] e, input int lat, input int hold);
    int k, t;
    exp_t x;
    logic [W-1:0] r0;
    @(negedge clk);
    t = 0;
    while (!bus.cmd_ready && t < 20) begin @(negedge clk); t++; end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_ready_wait op=%0d got %b need 1", op, bus.cmd_ready); return; end
    err_inj = e;
    bus.cmd_valid = 1; bus.cmd_opcode = op; bus.cmd_operand = b;
    x.err = is_special(op) ? 2'b00 : e;
    if (op == OP_PRESET) m_acc = b;
    else if (op == OP_GRND) begin m_acc = '0; m_sticky = 2'b00; end
    else if (op != OP_NOOP && x.err == 2'b00) m_acc = alu(op, m_acc, b);
    m_sticky |= x.err;
    x.res = m_acc;
    sb.push_back(x);
    @(posedge clk); #1;
    k = cyc;
    bus.cmd_valid = 0;
    n_cmp++;
    if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL no_back_to_back op=%0d cmd_ready got %b need 0", op, bus.cmd_ready); end
    t = 0;
    while (!bus.rsp_valid && t < 40) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (cyc - k + 1 !== lat) begin n_bad++; $display("FAIL rsp_latency op=%0d got cycle k+%0d need k+%0d", op, cyc - k + 1, lat); end
    if (!bus.rsp_valid) begin void'(sb.pop_front()); err_inj = 0; return; end
    r0 = bus.rsp_result;
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1; bus.cmd_opcode = OP_PRESET; bus.cmd_operand = 32'hdead;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_result} !== {1'b1, 1'b0, r0}) begin
        n_bad++; $display("FAIL hold_stable op=%0d cyc=%0d got v=%b r=%b res=%h need v=1 r=0 res=%h", op, i, bus.rsp_valid, bus.cmd_ready, bus.rsp_result, r0);
      end
    end
    bus.cmd_valid = 0;
    x = sb.pop_front();
    n_cmp++;
    if (bus.rsp_result !== x.res) begin n_bad++; $display("FAIL rsp_result op=%0d got %h need %h", op, bus.rsp_result, x.res); end
    n_cmp++;
    if (bus.rsp_error !== x.err) begin n_bad++; $display("FAIL rsp_error op=%0d got %b need %b", op, bus.rsp_error, x.err); end
    bus.rsp_ready = 1;
    @(posedge clk); #1;
    bus.rsp_ready = 0;
    err_inj = 0;
    n_cmp++;
    if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL rsp_done op=%0d got ready/valid %b%b need 10", op, bus.cmd_ready, bus.rsp_valid); end
    n_cmp++;
    if (acc !== m_acc) begin n_bad++; $display("FAIL acc op=%0d got %h need %h", op, acc, m_acc); end
    n_cmp++;
    if (err_sticky !== m_sticky) begin n_bad++; $display("FAIL err_sticky op=%0d got %b need %b", op, err_sticky, m_sticky); end
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({acc, err_sticky, bus.rsp_error, bus.rsp_valid, op_code, op_b} !== {32'd0, 2'b00, 2'b00, 1'b0, OP_NOOP, 32'd0}) begin
      n_bad++; $display("FAIL reset_state got acc=%h st=%b re=%b rv=%b op=%0d b=%h need zeros op=14", acc, err_sticky, bus.rsp_error, bus.rsp_valid, op_code, op_b);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b need 1", bus.cmd_ready); end
  endtask
  task automatic test_preset_add;
    cmd(OP_PRESET, 5, 2'b00, 1, 0);
    cmd(OP_ADD, 3, 2'b00, 2, 0);
    n_cmp++;
    if (acc !== 32'd8) begin n_bad++; $display("FAIL preset_add_acc got %0d need 8", acc); end
  endtask
  task automatic test_divzero_grnd;
    cmd(OP_DIV, 0, ERR_DIVZ, 1 + LAT, 0);
    n_cmp++;
    if ({acc, err_sticky} !== {32'd8, ERR_DIVZ}) begin n_bad++; $display("FAIL divzero got acc=%0d st=%b need 8/01", acc, err_sticky); end
    cmd(OP_GRND, 77, 2'b00, 1, 0);
    n_cmp++;
    if ({acc, err_sticky} !== {32'd0, 2'b00}) begin n_bad++; $display("FAIL grnd got acc=%0d st=%b need 0/00", acc, err_sticky); end
  endtask
  task automatic test_overflow;
    cmd(OP_PRESET, 100, 2'b00, 1, 0);
    cmd(OP_ADD, 32'hffff_ffff, ERR_OVF, 2, 0);
    cmd(OP_SUB, 30, 2'b00, 2, 0);
    n_cmp++;
    if ({acc, err_sticky} !== {32'd70, ERR_OVF}) begin n_bad++; $display("FAIL overflow_sub got acc=%0d st=%b need 70/10", acc, err_sticky); end
  endtask
  task automatic test_hold;
    cmd(OP_MULT, 6, 2'b00, 2, 6);
    n_cmp++;
    if (acc !== 32'd420) begin n_bad++; $display("FAIL hold_mult got %0d need 420", acc); end
  endtask
  task automatic test_reset_mid_exec;
    int seen = 0;
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_opcode = OP_MOD; bus.cmd_operand = 7;
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    m_acc = '0; m_sticky = 2'b00;
    n_cmp++;
    if ({acc, err_sticky, bus.rsp_error, bus.rsp_valid, bus.cmd_ready, op_code, op_b} !== {32'd0, 2'b00, 2'b00, 1'b0, 1'b1, OP_NOOP, 32'd0}) begin
      n_bad++; $display("FAIL reset_mid_exec got acc=%h st=%b re=%b rv=%b cr=%b op=%0d b=%h need 0/00/00/0/1/14/0", acc, err_sticky, bus.rsp_error, bus.rsp_valid, bus.cmd_ready, op_code, op_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (8) begin @(negedge clk); seen |= int'(bus.rsp_valid); end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL dropped_cmd rsp_valid got 1 need 0"); end
    cmd(OP_PRESET, 9, 2'b00, 1, 0);
    cmd(OP_MOD, 4, 2'b00, 1 + LAT, 0);
  endtask
  task automatic test_noop_reserved;
    cmd(OP_NOOP, 123, 2'b00, 1, 0);
    n_cmp++;
    if (acc !== 32'd1) begin n_bad++; $display("FAIL noop_acc got %0d need 1", acc); end
    cmd(4'd9, 32'h0f0f, 2'b00, 2, 0);
    n_cmp++;
    if (acc !== 32'h0f0e) begin n_bad++; $display("FAIL reserved9_acc got %h need 0f0e", acc); end
  endtask
  task automatic test_back_to_back;
    logic [3:0] ops [6];
    ops = '{OP_ADD, OP_MULT, OP_SUB, OP_AND, OP_DIV, OP_MOD};
    cmd(OP_PRESET, $urandom, 2'b00, 1, 0);
    for (int i = 0; i < 12; i++) begin
      logic [3:0] op = ops[i % 6];
      cmd(op, $urandom_range(1, 1000), 2'b00, is_multicycle(op) ? 1 + LAT : 2, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus.cmd_valid = 0; bus.cmd_opcode = 0; bus.cmd_operand = 0; bus.rsp_ready = 0;
    test_reset;
    test_preset_add;
    test_divzero_grnd;
    test_overflow;
    test_hold;
    test_reset_mid_exec;
    test_noop_reserved;
    test_back_to_back;
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_empty got %0d need 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequential controller for the calculator datapath: accepts one command at a time over a valid/ready interface and drives the 4-bit opcode into the decoder/multiplexer path. It holds the operation stable for the required number of cycles, then samples the multiplexer result and the 2-bit error code. It owns the 32-bit accumulator that feeds operand A back into the arithmetic units, and a sticky error register, and returns each result over a second valid/ready interface.

## Interface
- WIDTH, 32, datapath/accumulator width
- DIV_LATENCY, 4, cycles the divider/modulo units need before their output and divide-by-zero flag are valid (legal range 1..15)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_opcode  in  4  operation (0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 MOD, 5 AND, 6–12 reserved, 13 PRESET, 14 NO-OP, 15 GRND)
- cmd_operand  in  WIDTH  operand B / preset value
- op_code  out  4  opcode to decoder
- op_a  out  WIDTH  operand A to arithmetic units (= acc)
- op_b  out  WIDTH  operand B to arithmetic units
- mux_result  in  WIDTH  multiplexer output
- error_code  in  2  from error logic: bit1 overflow, bit0 divide-by-zero
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WIDTH  accumulator value after the command
- rsp_error  out  2  error_code sampled for this command (00 if none)
- acc  out  WIDTH  current accumulator
- err_sticky  out  2  OR of all errors since last GRND/reset

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1, op_code=14 (NO-OP).
  - On cmd_valid, latch opcode and operand into internal registers.
  - Opcode 13/14/15: go to RESP directly, no datapath wait.
  - Otherwise: go to EXEC and load the timer with DIV_LATENCY for opcodes 3/4, or 1 for all others (reserved opcodes included).
- EXEC:
  - op_code=latched opcode; op_b=latched operand; timer decrements each cycle.
  - On the cycle the timer equals 1, sample mux_result and error_code, then go to RESP.
  - error_code==00: acc<=mux_result. Non-zero: acc unchanged.
  - err_sticky |= error_code; rsp_error<=error_code.
- Special opcodes (applied on the accept edge):
  - PRESET: acc<=operand, rsp_error=00.
  - NO-OP: acc unchanged, rsp_error=00.
  - GRND: acc<=0, err_sticky<=00, rsp_error=00.
- RESP:
  - rsp_valid=1; rsp_result=acc; op_code=14.
  - rsp_result and rsp_error stay stable until rsp_ready; on rsp_valid&&rsp_ready go to IDLE.
- Arithmetic: results are truncated to WIDTH; the controller never modifies mux_result.
- Reset (any time, including mid-EXEC): state=IDLE, acc=0, err_sticky=00, rsp_error=00, rsp_valid=0, cmd_ready=1 after reset deasserts, op_code=14, op_b=0, timer=0. An in-flight command is dropped without a response.

## Timing
- Accept at edge k (cmd_valid&&cmd_ready).
- Single-cycle op: op_code valid during cycle k+1; sample at edge k+2; rsp_valid high from cycle k+2.
- DIV/MOD: sample at edge k+1+DIV_LATENCY.
- PRESET/NO-OP/GRND: rsp_valid high from cycle k+1.
- If rsp_ready is already high, the response completes in one cycle and cmd_ready returns the following cycle. Throughput is at most one command every 3 cycles for single-cycle ops; no back-to-back accept.
- cmd_ready is a registered state decode and does not depend on cmd_valid. rsp_valid does not depend on rsp_ready.
- op_a changes only on sample/accept edges, so inputs stay stable throughout EXEC.

## Structure
- Shared package calc_pkg:
  - Opcode constants: OP_ADD..OP_AND, OP_PRESET=13, OP_NOOP=14, OP_GRND=15.
  - Error constants: ERR_NONE=00, ERR_DIVZ=01, ERR_OVF=10.
  - State enum for calc_sequencer.
  - is_multicycle(opcode) function.
- One sub-module, calc_op_timer: loadable 4-bit down-counter with a done output; instantiated once.

## Test plan
- Reset, PRESET 5, ADD operand 3 (bench model returns 8): rsp_result=8 at cycle k+2, rsp_error=00, acc=8.
- DIV operand 0, divide-by-zero flag asserted, DIV_LATENCY=4: response at k+5, rsp_error=01, acc unchanged, err_sticky=01. A following GRND gives acc=0, err_sticky=00.
- ADD with overflow flag: rsp_error=10, acc unchanged. A subsequent SUB with no error updates acc; err_sticky stays 10.
- Hold rsp_ready low for 6 cycles after a MULT: rsp_valid/rsp_result stable; cmd_ready=0 throughout; cmd_valid during the hold is ignored.
- Assert rst_n low in the second EXEC cycle of MOD: all outputs return to reset values immediately; no response is issued; the next command proceeds normally.
- NO-OP and reserved opcode 9: NO-OP responds at k+1 with acc unchanged; opcode 9 completes in single-cycle timing with mux_result written to acc.
